zigbee_out_serializer: RTL and testbench

ZIGBEE_OUT_SERIALIZER -- requirements
Module: zigbee_out_serializer

---
 rtl/zigbee_out_serializer_if.sv | 30 +++
 rtl/zigbee_out_serializer.sv | 133 +++++++++++++
 tb/tb_zigbee_out_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/zigbee_out_serializer_if.sv
// Zigbee output serializer bus.
// Bundles the word handshake toward the serializer and the slice bus
// toward the output pads.
//   data_i  : 64-bit result word to transmit
//   valid_i : data_i is valid
//   ready_o : serializer can take a word this cycle
//   mux_o   : 18-bit slice currently on the pad bus
//   sel_o   : index of the slice on mux_o
//   frame_o : high while slice 0 of a frame is on mux_o
//   busy_o  : high while a frame is being sent
// Modports: master = word producer / pad consumer, slave = serializer.
interface zigbee_out_serializer_if;
  logic [63:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [17:0] mux_o;
  logic [1:0]  sel_o;
  logic        frame_o;
  logic        busy_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, mux_o, sel_o, frame_o, busy_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, mux_o, sel_o, frame_o, busy_o
  );
endinterface

// File: rtl/zigbee_out_serializer.sv
// Zigbee output serializer.
// Takes a 64-bit word plus an 8-bit XOR checksum of its bytes and sends it
// over an 18-bit pad bus as four slices, each held for HOLD cycles:
//   slice 0 = data[17:0], slice 1 = data[35:18], slice 2 = data[53:36],
//   slice 3 = {chk, data[63:54]}.
// A new word can be taken in the last cycle of slice 3, giving gap-free
// back-to-back frames.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : serializer side of zigbee_out_serializer_if (see that file)
// Parameter:
//   HOLD  : cycles per slice, 1..255
module zigbee_out_serializer #(
  parameter int HOLD = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  zigbee_out_serializer_if.slave       bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] LAST = 8'(HOLD - 1);

  state_t      state, state_nxt;
  logic [71:0] frame_q, frame_nxt;
  logic [1:0]  sel_q, sel_nxt;
  logic [7:0]  cnt_q, cnt_nxt;
  logic [17:0] mux_q, mux_nxt;
  logic        frm_q, frm_nxt;
  logic        ready;
  logic        accept;

  function automatic logic [7:0] checksum(input logic [63:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c ^ d[8*i +: 8];
    return c;
  endfunction

  // The frame register is laid out as {chk, data}, so slice n is simply
  // bits [18n+17:18n].
  function automatic logic [17:0] slice(input logic [71:0] f, input logic [1:0] idx);
    logic [17:0] s;
    case (idx)
      2'd0:    s = f[17:0];
      2'd1:    s = f[35:18];
      2'd2:    s = f[53:36];
      default: s = f[71:54];
    endcase
    return s;
  endfunction

  assign ready  = (state == IDLE) ||
                  ((state == SEND) && (sel_q == 2'd3) && (cnt_q == LAST));
  assign accept = bus.valid_i && ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      frame_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      mux_q   <= '0;
      frm_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      frame_q <= frame_nxt;
      sel_q   <= sel_nxt;
      cnt_q   <= cnt_nxt;
      mux_q   <= mux_nxt;
      frm_q   <= frm_nxt;
    end
  end

  // mux_o/sel_o/frame_o are computed one cycle ahead so the pad bus is
  // driven straight from flops.
  always_comb begin
    state_nxt = state;
    frame_nxt = frame_q;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt_q;
    mux_nxt   = mux_q;
    frm_nxt   = frm_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
          frame_nxt = {checksum(bus.data_i), bus.data_i};
          sel_nxt   = 2'd0;
          cnt_nxt   = '0;
          mux_nxt   = bus.data_i[17:0];
          frm_nxt   = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == LAST) begin
          if (sel_q == 2'd3) begin
            if (accept) begin
              frame_nxt = {checksum(bus.data_i), bus.data_i};
              sel_nxt   = 2'd0;
              cnt_nxt   = '0;
              mux_nxt   = bus.data_i[17:0];
              frm_nxt   = 1'b1;
            end else begin
              state_nxt = IDLE;
              sel_nxt   = 2'd0;
              cnt_nxt   = '0;
              mux_nxt   = '0;
              frm_nxt   = 1'b0;
            end
          end else begin
            sel_nxt = sel_q + 2'd1;
            cnt_nxt = '0;
            mux_nxt = slice(frame_q, sel_q + 2'd1);
            frm_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ready_o = ready;
  assign bus.busy_o  = (state == SEND);
  assign bus.mux_o   = mux_q;
  assign bus.sel_o   = sel_q;
  assign bus.frame_o = frm_q;

endmodule

// File: tb/tb_zigbee_out_serializer.sv
// Bench for zigbee_out_serializer: one instance with HOLD=4 and one with
// HOLD=1, both checked against a slice scoreboard filled at each accepted word.
module tb_zigbee_out_serializer;

  localparam int H0 = 4;
  localparam int H1 = 1;

  typedef struct packed {
    logic        frm;
    logic [1:0]  sel;
    logic [17:0] mux;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  zigbee_out_serializer_if bus0 ();
  zigbee_out_serializer_if bus1 ();

  zigbee_out_serializer #(.HOLD(H0)) u0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  zigbee_out_serializer #(.HOLD(H1)) u1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   m0 = 0, m1 = 0;
  int   run0 = 0, run1 = 0;
  int   last_run0 = 0, last_run1 = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_chk(input logic [63:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 8; i++) c = c ^ d[8*i +: 8];
    return c;
  endfunction

  task automatic push_exp(input int inst, input logic [63:0] d);
    logic [17:0] s [4];
    exp_t e;
    s[0] = d[17:0];
    s[1] = d[35:18];
    s[2] = d[53:36];
    s[3] = {ref_chk(d), d[63:54]};
    for (int i = 0; i < 4; i++) begin
      e.frm = (i == 0);
      e.sel = 2'(i);
      e.mux = s[i];
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
  endtask

  // Presents a word and waits (bounded) until it is taken.
  task automatic send(input int inst, input logic [63:0] d);
    int   tries;
    logic rdy;
    tries = 0;
    @(negedge clk);
    if (inst == 0) begin bus0.valid_i = 1'b1; bus0.data_i = d; end
    else           begin bus1.valid_i = 1'b1; bus1.data_i = d; end
    rdy = (inst == 0) ? bus0.ready_o : bus1.ready_o;
    while (!rdy && tries < 200) begin
      @(negedge clk);
      tries++;
      rdy = (inst == 0) ? bus0.ready_o : bus1.ready_o;
    end
    if (!rdy) check_val("send_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk);
      push_exp(inst, d);
    end
  endtask

  task automatic release_bus(input int inst);
    @(negedge clk);
    if (inst == 0) begin bus0.valid_i = 1'b0; bus0.data_i = {$urandom, $urandom}; end
    else           begin bus1.valid_i = 1'b0; bus1.data_i = {$urandom, $urandom}; end
  endtask

  // Monitor for HOLD=4 instance
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus0.busy_o) begin
        run0++;
        if (q0.size() == 0) check_val("u0_unexpected_busy", 64'd1, 64'd0);
        else begin
          check_val("u0_slice",
                    {bus0.ready_o, bus0.frame_o, bus0.sel_o, bus0.mux_o},
                    {(m0 == H0 - 1) && (q0[0].sel == 2'd3), q0[0]});
          m0++;
          if (m0 == H0) begin void'(q0.pop_front()); m0 = 0; end
        end
      end else begin
        if (run0 != 0) last_run0 = run0;
        run0 = 0;
        check_val("u0_idle",
                  {bus0.ready_o, bus0.frame_o, bus0.sel_o, bus0.mux_o, q0.size() == 0},
                  {1'b1, 21'd0, 1'b1});
      end
    end
  end

  // Monitor for HOLD=1 instance
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus1.busy_o) begin
        run1++;
        if (q1.size() == 0) check_val("u1_unexpected_busy", 64'd1, 64'd0);
        else begin
          check_val("u1_slice",
                    {bus1.ready_o, bus1.frame_o, bus1.sel_o, bus1.mux_o},
                    {(m1 == H1 - 1) && (q1[0].sel == 2'd3), q1[0]});
          m1++;
          if (m1 == H1) begin void'(q1.pop_front()); m1 = 0; end
        end
      end else begin
        if (run1 != 0) last_run1 = run1;
        run1 = 0;
        check_val("u1_idle",
                  {bus1.ready_o, bus1.frame_o, bus1.sel_o, bus1.mux_o, q1.size() == 0},
                  {1'b1, 21'd0, 1'b1});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    int          tries;
    rst = 1'b1;
    bus0.valid_i = 1'b0; bus0.data_i = '0;
    bus1.valid_i = 1'b0; bus1.data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out", {bus0.busy_o, bus0.frame_o, bus0.sel_o, bus0.mux_o}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // single word, known pattern
    send(0, 64'h0123456789ABCDEF);
    release_bus(0);
    check_val("single_s0", {bus0.frame_o, bus0.mux_o}, {1'b1, 18'h3CDEF});
    repeat (20) @(negedge clk);
    check_val("single_busy_len", last_run0, 16);

    // checksum slice
    send(0, 64'h00000000000000FF);
    release_bus(0);
    repeat (12) @(negedge clk);
    check_val("chk_slice3", {bus0.sel_o, bus0.mux_o}, {2'd3, 18'h3FC00});
    repeat (10) @(negedge clk);

    // back-to-back
    send(0, {$urandom, $urandom});
    send(0, {$urandom, $urandom});
    release_bus(0);
    repeat (40) @(negedge clk);
    check_val("b2b_busy_len", last_run0, 32);

    // backpressure: valid raised in frame cycle 5, data wiggles until taken
    send(0, {$urandom, $urandom});
    w = {$urandom, $urandom};
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 5)  begin bus0.valid_i = 1'b1; bus0.data_i = {$urandom, $urandom}; end
      if (k == 9)  bus0.data_i = {$urandom, $urandom};
      if (k == 16) bus0.data_i = w;
      if (k >= 5) check_val("bp_ready", bus0.ready_o, (k == 16));
    end
    @(posedge clk);
    push_exp(0, w);
    release_bus(0);
    repeat (20) @(negedge clk);
    check_val("bp_busy_len", last_run0, 32);

    // reset during slice 2
    send(0, {$urandom, $urandom});
    release_bus(0);
    tries = 0;
    while (bus0.sel_o != 2'd2 && tries < 50) begin @(negedge clk); tries++; end
    check_val("reach_slice2", bus0.sel_o, 2'd2);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check_val("rst_mid_out", {bus0.busy_o, bus0.frame_o, bus0.sel_o, bus0.mux_o}, 64'd0);
    q0.delete(); m0 = 0; run0 = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("rdy_after_rst", bus0.ready_o, 1'b1);
    send(0, {$urandom, $urandom});
    release_bus(0);
    repeat (20) @(negedge clk);
    check_val("post_rst_busy_len", last_run0, 16);

    // HOLD=1, four words back-to-back
    for (int i = 0; i < 4; i++) send(1, {$urandom, $urandom});
    release_bus(1);
    repeat (10) @(negedge clk);
    check_val("h1_busy_len", last_run1, 16);

    check_val("queues_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
